// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//   Pipeline register between instruction fetch (IF) and instruction decode
//   (ID) with valid/ready handshaking, flush support and a saturating stall
//   counter.
//
//   Optional feature: define IF_ID_SKID_EN to add a one-entry skid buffer.
//   in_ready then comes straight from a flop instead of depending
//   combinationally on out_ready.
//
// Parameters
//   INSTR_W    instruction width
//   ADDR_W     PC+4 width
//   NOP_INSTR  bubble instruction shown when no valid entry is held
//   CNT_W      stall counter width
//
// Ports
//   clk                   sole clock, rising edge
//   rst                   synchronous active-high reset
//   in_valid / in_ready   IF-side handshake
//   instruction           fetched instruction
//   instru_addr_plus4     PC+4 of the fetched instruction
//   ifflush               squash the stage contents (taken branch/jump)
//   out_valid / out_ready ID-side handshake
//   instru_out            registered instruction
//   instru_addr_plus4_out registered PC+4
//   stall_cnt             saturating count of cycles with out_valid && !out_ready
// -----------------------------------------------------------------------------
module if_id_stage #(
   parameter int                 INSTR_W   = 32,
   parameter int                 ADDR_W    = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruction,
   input  logic [ADDR_W-1:0]  instru_addr_plus4,
   input  logic               ifflush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] instru_out,
   output logic [ADDR_W-1:0]  instru_addr_plus4_out,
   output logic [CNT_W-1:0]   stall_cnt
);

   logic               r_out_valid;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_addr;
   logic [CNT_W-1:0]   r_stall_cnt;

   logic w_accept;
   logic w_stall;

   assign w_stall  = r_out_valid && !out_ready;
   assign w_accept = in_valid && in_ready;

`ifdef IF_ID_SKID_EN
   logic               r_skid_valid;
   logic [INSTR_W-1:0] r_skid_instr;
   logic [ADDR_W-1:0]  r_skid_addr;

   // Ready depends only on skid occupancy, so the ready path is fully registered.
   assign in_ready = !r_skid_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_instr      <= NOP_INSTR;
         r_addr       <= '0;
         r_skid_valid <= 1'b0;
         r_skid_instr <= NOP_INSTR;
         r_skid_addr  <= '0;
      end else if (ifflush) begin
         r_out_valid  <= 1'b0;
         r_instr      <= NOP_INSTR;
         r_addr       <= '0;
         r_skid_valid <= 1'b0;
      end else if (w_stall) begin
         // Main entry held; a new input parks in the (necessarily empty) skid.
         if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= instruction;
            r_skid_addr  <= instru_addr_plus4;
         end
      end else if (r_skid_valid) begin
         // Older skid entry goes first; in_ready is low so nothing is accepted.
         r_out_valid  <= 1'b1;
         r_instr      <= r_skid_instr;
         r_addr       <= r_skid_addr;
         r_skid_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_instr      <= instruction;
         r_addr       <= instru_addr_plus4;
      end else begin
         r_out_valid  <= 1'b0;
         r_instr      <= NOP_INSTR;
         r_addr       <= '0;
      end
   end
`else
   assign in_ready = !r_out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_instr     <= NOP_INSTR;
         r_addr      <= '0;
      end else if (ifflush) begin
         r_out_valid <= 1'b0;
         r_instr     <= NOP_INSTR;
         r_addr      <= '0;
      end else if (w_stall) begin
         r_out_valid <= r_out_valid;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_instr     <= instruction;
         r_addr      <= instru_addr_plus4;
      end else begin
         r_out_valid <= 1'b0;
         r_instr     <= NOP_INSTR;
         r_addr      <= '0;
      end
   end
`endif

   // Counts stall cycles even when a flush coincides; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign out_valid             = r_out_valid;
   assign instru_out            = r_instr;
   assign instru_addr_plus4_out = r_addr;
   assign stall_cnt             = r_stall_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
//   Self-checking bench for if_id_stage. The reference model is an ordered
//   queue of accepted-but-unconsumed entries whose capacity is 1 (plain) or 2
//   (IF_ID_SKID_EN). A second instance with CNT_W=2 and a non-zero NOP_INSTR
//   shares the stimulus to exercise counter saturation and the bubble value.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

   localparam logic [31:0] NOP_S = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] instru_addr_plus4;
   logic        ifflush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instru_out;
   logic [31:0] instru_addr_plus4_out;
   logic [15:0] stall_cnt;

   logic        in_ready_s;
   logic        out_valid_s;
   logic [31:0] instru_out_s;
   logic [31:0] addr_out_s;
   logic [1:0]  stall_cnt_s;

   always #5 clk = ~clk;

   if_id_stage u_dut (
      .clk                   (clk),
      .rst                   (rst),
      .in_valid              (in_valid),
      .in_ready              (in_ready),
      .instruction           (instruction),
      .instru_addr_plus4     (instru_addr_plus4),
      .ifflush               (ifflush),
      .out_valid             (out_valid),
      .out_ready             (out_ready),
      .instru_out            (instru_out),
      .instru_addr_plus4_out (instru_addr_plus4_out),
      .stall_cnt             (stall_cnt)
   );

   if_id_stage #(.CNT_W(2), .NOP_INSTR(NOP_S)) u_dut_small (
      .clk                   (clk),
      .rst                   (rst),
      .in_valid              (in_valid),
      .in_ready              (in_ready_s),
      .instruction           (instruction),
      .instru_addr_plus4     (instru_addr_plus4),
      .ifflush               (ifflush),
      .out_valid             (out_valid_s),
      .out_ready             (out_ready),
      .instru_out            (instru_out_s),
      .instru_addr_plus4_out (addr_out_s),
      .stall_cnt             (stall_cnt_s)
   );

   // Reference model state
   logic [63:0] model_q[$];
   int          cnt_big;
   int          cnt_small;
   bit          model_init;

   int checks;
   int errors;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check in_ready, clock, advance model, check outputs.
   task automatic step(input bit r, input bit iv, input logic [31:0] ins,
                       input logic [31:0] ad, input bit fl, input bit ordy);
      bit          exp_rdy;
      bit          acc;
      bit          cons;
      bit          stl;
      logic [31:0] exp_instr;
      logic [31:0] exp_instr_s;
      logic [31:0] exp_addr;
      rst               = r;
      in_valid          = iv;
      instruction       = ins;
      instru_addr_plus4 = ad;
      ifflush           = fl;
      out_ready         = ordy;
      #1;
`ifdef IF_ID_SKID_EN
      exp_rdy = (model_q.size() < 2);
`else
      exp_rdy = (model_q.size() == 0) || ordy;
`endif
      if (model_init) begin
         check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
         check("in_ready_small", {63'd0, in_ready_s}, {63'd0, exp_rdy});
      end
      acc  = iv && exp_rdy;
      cons = (model_q.size() > 0) && ordy;
      stl  = (model_q.size() > 0) && !ordy;
      @(posedge clk);
      #1;
      if (r) begin
         model_q.delete();
         cnt_big    = 0;
         cnt_small  = 0;
         model_init = 1'b1;
      end else begin
         if (stl) begin
            if (cnt_big < 65535) cnt_big++;
            if (cnt_small < 3) cnt_small++;
         end
         if (fl) begin
            model_q.delete();
         end else begin
            if (cons) void'(model_q.pop_front());
            if (acc) model_q.push_back({ins, ad});
         end
      end
      if (model_init) begin
         if (model_q.size() > 0) begin
            exp_instr   = model_q[0][63:32];
            exp_instr_s = model_q[0][63:32];
            exp_addr    = model_q[0][31:0];
         end else begin
            exp_instr   = 32'd0;
            exp_instr_s = NOP_S;
            exp_addr    = 32'd0;
         end
         check("out_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
         check("instru_out", {32'd0, instru_out}, {32'd0, exp_instr});
         check("addr_out", {32'd0, instru_addr_plus4_out}, {32'd0, exp_addr});
         check("stall_cnt", {48'd0, stall_cnt}, 64'(cnt_big));
         check("out_valid_small", {63'd0, out_valid_s}, {63'd0, model_q.size() > 0});
         check("instru_out_small", {32'd0, instru_out_s}, {32'd0, exp_instr_s});
         check("addr_out_small", {32'd0, addr_out_s}, {32'd0, exp_addr});
         check("stall_cnt_small", {62'd0, stall_cnt_s}, 64'(cnt_small));
      end
   endtask

   initial begin
      checks            = 0;
      errors            = 0;
      cnt_big           = 0;
      cnt_small         = 0;
      model_init        = 1'b0;
      rst               = 1'b1;
      in_valid          = 1'b0;
      instruction       = 32'd0;
      instru_addr_plus4 = 32'd0;
      ifflush           = 1'b0;
      out_ready         = 1'b0;
      @(posedge clk);
      #1;

      // Reset with a valid input present; next cycle in_ready must be 1.
      step(1, 1, 32'h8C01_0004, 32'h4, 0, 1);
      check("reset_stall_cnt", {48'd0, stall_cnt}, 64'd0);
      step(0, 0, 32'h0, 32'h0, 0, 1);

      // Streaming two entries back to back.
      step(0, 1, 32'h8C01_0004, 32'h4, 0, 1);
      step(0, 1, 32'h0022_1820, 32'h8, 0, 1);
      step(0, 0, 32'h0, 32'h0, 0, 1);

      // Load, stall for three cycles with a second entry offered, then drain.
      step(0, 1, 32'h8C01_0004, 32'h4, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 32'h0022_1820, 32'h8, 0, 0);
      check("stall_cnt_three", {48'd0, stall_cnt}, 64'd3);
      step(0, 1, 32'h0022_1820, 32'h8, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 32'h0, 0, 1);

      // Flush with a valid entry held and a new input offered.
      step(0, 1, 32'h1234_5678, 32'h10, 0, 0);
      step(0, 1, 32'hDEAD_BEEF, 32'h14, 1, 0);
      step(0, 0, 32'h0, 32'h0, 0, 1);
      step(0, 0, 32'h0, 32'h0, 0, 1);

      // Saturation of the 2-bit counter from a clean reset.
      step(1, 0, 32'h0, 32'h0, 0, 0);
      step(0, 1, 32'hAAAA_0001, 32'h20, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 32'h0, 0, 0);
      check("small_saturated", {62'd0, stall_cnt_s}, 64'd3);
      check("big_five", {48'd0, stall_cnt}, 64'd5);

      // Reset in the middle of a stall with the skid (if present) full.
      step(0, 1, 32'hBBBB_0002, 32'h24, 0, 0);
      step(0, 1, 32'hCCCC_0003, 32'h28, 0, 0);
      step(1, 1, 32'hDDDD_0004, 32'h2C, 0, 0);
      step(0, 0, 32'h0, 32'h0, 0, 0);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 9) < 7,
              $urandom,
              $urandom,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 9) < 6);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction field width.
REQ-002 SHALL have parameter ADDR_W, default 32, PC+4 field width.
REQ-003 SHALL have parameter NOP_INSTR, default 0 (INSTR_W bits), bubble instruction value.
REQ-004 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  IF presents a fetched instruction.
REQ-008 SHALL have port in_ready  output  1  stage accepts input this cycle.
REQ-009 SHALL have port instruction  input  INSTR_W  fetched instruction.
REQ-010 SHALL have port instru_addr_plus4  input  ADDR_W  PC+4 of the fetched instruction.
REQ-011 SHALL have port ifflush  input  1  squash stage contents (branch/jump taken).
REQ-012 SHALL have port out_valid  output  1  ID-side entry valid.
REQ-013 SHALL have port out_ready  input  1  ID consumes the entry this cycle.
REQ-014 SHALL have port instru_out  output  INSTR_W  registered instruction.
REQ-015 SHALL have port instru_addr_plus4_out  output  ADDR_W  registered PC+4.
REQ-016 SHALL have port stall_cnt  output  CNT_W  count of stall cycles.

Function
REQ-017 SHALL define accept = in_valid && in_ready and consume = out_valid && out_ready.
REQ-018 SHALL, when out_valid && !out_ready (stall), hold instru_out, instru_addr_plus4_out and out_valid unchanged.
REQ-019 SHALL, when not stalled and not flushed, load the next entry with 1-cycle latency: if accepted, out_valid=1 with input data; otherwise out_valid=0, instru_out=NOP_INSTR, instru_addr_plus4_out=0.
REQ-020 SHALL give ifflush priority over every other event: next edge out_valid=0, instru_out=NOP_INSTR, instru_addr_plus4_out=0, and any skid entry discarded.
REQ-021 SHALL discard an input accepted in the same cycle as ifflush; in_ready is unaffected by ifflush.
REQ-022 SHALL never drop, duplicate or reorder accepted entries absent ifflush.
REQ-023 SHALL increment stall_cnt by 1 in each cycle with out_valid && !out_ready, saturating at 2^CNT_W-1 without wrap; ifflush does not clear it.
REQ-024 SHALL drive out_valid and data outputs directly from flops, with no combinational path from inputs.

Reset
REQ-025 SHALL, on a rising clk edge with rst=1, set out_valid=0, instru_out=NOP_INSTR, instru_addr_plus4_out=0, stall_cnt=0, and clear the skid entry.
REQ-026 SHALL give rst priority over ifflush, stall and accept; an entry in flight when rst asserts is lost.
REQ-027 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, with macro IF_ID_SKID_EN undefined, drive in_ready = !out_valid || out_ready, combinationally.
REQ-029 SHALL, with IF_ID_SKID_EN defined, add one skid entry and drive in_ready = !skid_valid from a flop, so in_ready has no combinational path from out_ready.
REQ-030 SHALL, with IF_ID_SKID_EN defined, place an entry accepted during a stall into the skid entry. When the main entry is consumed or empty, the skid entry moves to the main register before any new input.
REQ-031 SHALL, with IF_ID_SKID_EN defined, sustain one transfer per cycle when out_ready=1 continuously.

Verification
REQ-032 SHALL cover reset: rst=1 one edge with in_valid=1 -> out_valid=0, instru_out=0, stall_cnt=0; next cycle in_ready=1.
REQ-033 SHALL cover streaming: out_ready=1, entries {0x8C010004, 0x00000004}, {0x00221820, 0x00000008} on consecutive cycles -> same values on outputs one cycle later each, out_valid=1.
REQ-034 SHALL cover stall: entry 0x8C010004 loaded, out_ready=0 for 3 cycles -> outputs held, stall_cnt=3. Without skid, in_ready=0 during the stall. With skid, the second entry is captured and appears right after the first.
REQ-035 SHALL cover flush: ifflush=1 with out_valid=1, in_valid=1 -> next cycle out_valid=0, instru_out=NOP_INSTR, instru_addr_plus4_out=0, and the input is not delivered.
REQ-036 SHALL cover saturation: CNT_W=2, out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=3, no wrap.
REQ-037 SHALL cover reset mid-stall: skid entry full and rst=1 -> next cycle out_valid=0, skid empty, in_ready=1.
